// File: rtl/fir_mac_serial.sv
`default_nettype none
// ============================================================================
// Module   : fir_mac_serial
// Brief    : Time-multiplexed single-multiplier FIR, one tap per cycle,
//            full-precision Q(ACC_M).ACC_N output with valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module fir_mac_serial #(
    parameter  int TAPS  = 16,
    parameter  int N_X   = 15,
    parameter  int N_C   = 15,
    localparam int G     = $clog2(TAPS),
    localparam int ACC_M = 2 + G,
    localparam int ACC_N = N_X + N_C,
    localparam int ACC_W = ACC_M + ACC_N
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_X:0]     sample_i,
    input  logic             sample_valid_i,
    output logic             sample_ready_o,
    input  logic             coef_we_i,
    input  logic [G-1:0]     coef_addr_i,
    input  logic [N_C:0]     coef_data_i,
    output logic [ACC_W-1:0] acc_o,
    output logic             acc_valid_o,
    input  logic             acc_ready_i,
    output logic             busy_o
);

    localparam int PROD_W = N_X + N_C + 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic signed [N_X:0]    r_x [TAPS];
    logic signed [N_C:0]    r_c [TAPS];
    logic [G-1:0]           r_wptr;
    logic [G-1:0]           r_k;
    logic [G-1:0]           w_idx;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0] w_prod_ext;
    logic signed [ACC_W-1:0] w_sum;
    logic                   w_accept;
    logic                   w_last;

    assign sample_ready_o = (r_state == ST_IDLE) && !rst_i;
    assign busy_o         = (r_state != ST_IDLE);
    assign acc_valid_o    = (r_state == ST_DONE);
    assign w_accept       = sample_valid_i && sample_ready_o;
    assign w_last         = (r_k == G'(TAPS - 1));

    // Index arithmetic wraps naturally because TAPS is a power of two.
    assign w_idx      = r_wptr - r_k;
    assign w_prod     = r_x[w_idx] * r_c[r_k];
    assign w_prod_ext = {{(ACC_W - PROD_W){w_prod[PROD_W-1]}}, w_prod};
    assign w_sum      = r_acc + w_prod_ext;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)    w_state_nxt = ST_MAC;
            ST_MAC:  if (w_last)      w_state_nxt = ST_DONE;
            ST_DONE: if (acc_ready_i) w_state_nxt = ST_IDLE;
            default:                  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < TAPS; i++) begin
                r_x[i] <= '0;
                r_c[i] <= '0;
            end
            r_wptr <= '0;
            r_k    <= '0;
            r_acc  <= '0;
            acc_o  <= '0;
        end else begin
            // Coefficients are frozen outside IDLE so a sample never sees a mix.
            if ((r_state == ST_IDLE) && coef_we_i) begin
                r_c[coef_addr_i] <= coef_data_i;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_x[r_wptr] <= sample_i;
                        r_acc       <= '0;
                        r_k         <= '0;
                    end
                end
                ST_MAC: begin
                    r_acc <= w_sum;
                    r_k   <= r_k + G'(1);
                    if (w_last) begin
                        acc_o <= w_sum;
                    end
                end
                ST_DONE: begin
                    if (acc_ready_i) begin
                        r_wptr <= r_wptr + G'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
